// File: rtl/fsm_mestre_envase_pkg.sv
// Shared encodings and default timing constants for the bottling-line sequencer.
package pkg_linha_envase;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_MOV_ENCH  = 4'd1;
    localparam logic [3:0] ST_ENCHER    = 4'd2;
    localparam logic [3:0] ST_VEDAR     = 4'd3;
    localparam logic [3:0] ST_MOV_CQ    = 4'd4;
    localparam logic [3:0] ST_VERIFICAR = 4'd5;
    localparam logic [3:0] ST_DESCARTE  = 4'd6;
    localparam logic [3:0] ST_FIM       = 4'd7;
    localparam logic [3:0] ST_ERRO      = 4'd8;

    localparam logic FASE_CMD = 1'b0;
    localparam logic FASE_LIB = 1'b1;

    localparam int CONT_W_DEF          = 8;
    localparam int DESCARTE_CICLOS_DEF = 50_000_000;
    localparam int TIMEOUT_CICLOS_DEF  = 500_000_000;

    // States that run a CMD/LIB handshake with a slave station.
    function automatic logic eh_tarefa(input logic [3:0] st);
        return (st == ST_MOV_ENCH) || (st == ST_ENCHER) || (st == ST_VEDAR) ||
               (st == ST_MOV_CQ)   || (st == ST_VERIFICAR);
    endfunction

endpackage

// File: rtl/fsm_mestre_envase_contador.sv
// Saturating up-counter used for the approved and discarded bottle tallies.
module contador_saturado
    import pkg_linha_envase::*;
#(
    parameter int CONT_W = CONT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc,
    output logic [CONT_W-1:0] valor
);

    logic [CONT_W-1:0] valor_q;
    logic [CONT_W-1:0] valor_d;

    // Increment unless already at all-ones.
    always_comb begin
        if (inc && (valor_q != {CONT_W{1'b1}})) begin
            valor_d = valor_q + CONT_W'(1);
        end else begin
            valor_d = valor_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valor_q <= {CONT_W{1'b0}};
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/fsm_mestre_envase.sv
// Master sequencer of the bottling line: fill, cap, CQ check and discard per bottle.
// Optional per-phase watchdog with ERRO state enabled by defining FSM_MESTRE_WATCHDOG_EN.
module fsm_mestre_envase
    import pkg_linha_envase::*;
#(
    parameter int CONT_W          = CONT_W_DEF,
    parameter int DESCARTE_CICLOS = DESCARTE_CICLOS_DEF,
    parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pulso_start,
    input  logic              pulso_stop,
    input  logic              mover_concluida,
    input  logic              encher_concluida,
    input  logic              vedar_concluida,
    input  logic              cq_concluida,
    input  logic              garrafa_aprovada,
    output logic              cmd_mover,
    output logic              cmd_encher,
    output logic              cmd_vedar,
    output logic              cmd_verificar,
    output logic              destino_cq,
    output logic              atuador_descarte,
    output logic              linha_ativa,
    output logic              erro,
    output logic [CONT_W-1:0] cont_aprovadas,
    output logic [CONT_W-1:0] cont_descartes
);

    localparam int DESC_W = $clog2(DESCARTE_CICLOS + 1);

    logic [3:0]        state_q, state_d;
    logic              fase_q, fase_d;
    logic              stop_q, stop_d;
    logic              veredito_q, veredito_d;
    logic [DESC_W-1:0] desc_cnt_q, desc_cnt_d;
    logic              done_s;
    logic [3:0]        prox_tarefa_s;
    logic              inc_aprov_s, inc_desc_s;

`ifdef FSM_MESTRE_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CICLOS;
`endif

    // State, latches and timers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fase_q     <= FASE_CMD;
            stop_q     <= 1'b0;
            veredito_q <= 1'b0;
            desc_cnt_q <= {DESC_W{1'b0}};
`ifdef FSM_MESTRE_WATCHDOG_EN
            wd_q       <= {WD_W{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            fase_q     <= fase_d;
            stop_q     <= stop_d;
            veredito_q <= veredito_d;
            desc_cnt_q <= desc_cnt_d;
`ifdef FSM_MESTRE_WATCHDOG_EN
            wd_q       <= wd_d;
`endif
        end
    end

    // Done level of the slave owning the current state, and the task that follows it.
    always_comb begin
        done_s        = 1'b0;
        prox_tarefa_s = ST_IDLE;
        case (state_q)
            ST_MOV_ENCH:  begin done_s = mover_concluida;  prox_tarefa_s = ST_ENCHER;    end
            ST_ENCHER:    begin done_s = encher_concluida; prox_tarefa_s = ST_VEDAR;     end
            ST_VEDAR:     begin done_s = vedar_concluida;  prox_tarefa_s = ST_MOV_CQ;    end
            ST_MOV_CQ:    begin done_s = mover_concluida;  prox_tarefa_s = ST_VERIFICAR; end
            ST_VERIFICAR: begin done_s = cq_concluida;     prox_tarefa_s = ST_FIM;       end
            default:      begin done_s = 1'b0;             prox_tarefa_s = ST_IDLE;      end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        fase_d      = fase_q;
        veredito_d  = veredito_q;
        inc_aprov_s = 1'b0;
        inc_desc_s  = 1'b0;
        desc_cnt_d  = (state_q == ST_DESCARTE) ? desc_cnt_q + DESC_W'(1) : {DESC_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (pulso_start && !pulso_stop) begin
                    state_d = ST_MOV_ENCH;
                    fase_d  = FASE_CMD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOV_ENCH, ST_ENCHER, ST_VEDAR, ST_MOV_CQ: begin
                if ((fase_q == FASE_CMD) && done_s) begin
                    fase_d = FASE_LIB;
                end else if ((fase_q == FASE_LIB) && !done_s) begin
                    state_d = prox_tarefa_s;
                    fase_d  = FASE_CMD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_VERIFICAR: begin
                if ((fase_q == FASE_CMD) && done_s) begin
                    fase_d     = FASE_LIB;
                    veredito_d = garrafa_aprovada;
                end else if ((fase_q == FASE_LIB) && !done_s) begin
                    fase_d = FASE_CMD;
                    if (veredito_q) begin
                        state_d     = ST_FIM;
                        inc_aprov_s = 1'b1;
                    end else begin
                        state_d    = ST_DESCARTE;
                        inc_desc_s = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DESCARTE: begin
                if (desc_cnt_q == DESC_W'(DESCARTE_CICLOS - 1)) begin
                    state_d = ST_FIM;
                end else begin
                    state_d = ST_DESCARTE;
                end
            end
            ST_FIM: begin
                fase_d  = FASE_CMD;
                state_d = stop_q ? ST_IDLE : ST_MOV_ENCH;
            end
`ifdef FSM_MESTRE_WATCHDOG_EN
            ST_ERRO: begin
                if (pulso_start && !mover_concluida && !encher_concluida &&
                    !vedar_concluida && !cq_concluida) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERRO;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                fase_d  = FASE_CMD;
            end
        endcase

`ifdef FSM_MESTRE_WATCHDOG_EN
        // A stalled handshake phase overrides any other decision.
        wd_d = {WD_W{1'b0}};
        if (eh_tarefa(state_q) && (state_d == state_q) && (fase_d == fase_q)) begin
            if (wd_q == WD_W'(TIMEOUT_CICLOS - 1)) begin
                state_d = ST_ERRO;
                fase_d  = FASE_CMD;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end else begin
            wd_d = {WD_W{1'b0}};
        end
`endif

        if (state_d == ST_IDLE) begin
            stop_d = 1'b0;
        end else if (pulso_stop && (state_q != ST_IDLE) && (state_q != ST_ERRO)) begin
            stop_d = 1'b1;
        end else begin
            stop_d = stop_q;
        end
    end

    // Moore outputs decoded from the registered state and phase.
    always_comb begin
        cmd_mover        = 1'b0;
        cmd_encher       = 1'b0;
        cmd_vedar        = 1'b0;
        cmd_verificar    = 1'b0;
        destino_cq       = 1'b0;
        atuador_descarte = 1'b0;
        case (state_q)
            ST_MOV_ENCH:  cmd_mover     = (fase_q == FASE_CMD);
            ST_ENCHER:    cmd_encher    = (fase_q == FASE_CMD);
            ST_VEDAR:     cmd_vedar     = (fase_q == FASE_CMD);
            ST_MOV_CQ: begin
                cmd_mover  = (fase_q == FASE_CMD);
                destino_cq = (fase_q == FASE_CMD);
            end
            ST_VERIFICAR: cmd_verificar = (fase_q == FASE_CMD);
            ST_DESCARTE:  atuador_descarte = 1'b1;
            default:      atuador_descarte = 1'b0;
        endcase
        linha_ativa = (state_q != ST_IDLE) && (state_q != ST_ERRO);
`ifdef FSM_MESTRE_WATCHDOG_EN
        erro = (state_q == ST_ERRO);
`else
        erro = 1'b0;
`endif
    end

    contador_saturado #(.CONT_W(CONT_W)) u_cont_aprovadas (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_aprov_s),
        .valor   (cont_aprovadas)
    );

    contador_saturado #(.CONT_W(CONT_W)) u_cont_descartes (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (inc_desc_s),
        .valor   (cont_descartes)
    );

endmodule

// File: doc/fsm_mestre_envase.md
# fsm_mestre_envase

Master sequencer for the bottling line. It walks one bottle at a time through four slave stations: conveyor move to fill, fill, cap, then conveyor move to CQ and the CQ check. It drives the discard actuator itself on a rejected bottle and keeps approved/discarded counts. It sits above the slave station FSMs and talks to each one over a level command / `*_concluida` handshake.

## Interface
- `CONT_W`, default 8: width of both bottle counters.
- `DESCARTE_CICLOS`, default 50_000_000: cycles the discard actuator is held high (1 s at 50 MHz).
- `TIMEOUT_CICLOS`, default 500_000_000: watchdog limit per handshake phase (10 s). Used only with `WATCHDOG_EN`.

Ports:
- `clk` in 1: 50 MHz clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `pulso_start` in 1: one-cycle debounced KEY pulse. Starts the line; also clears an error.
- `pulso_stop` in 1: one-cycle pulse. Requests a stop after the current bottle.
- `mover_concluida`, `encher_concluida`, `vedar_concluida`, `cq_concluida` in 1 each: slave done levels.
- `garrafa_aprovada` in 1: CQ verdict. Valid while `cq_concluida`=1.
- `cmd_mover`, `cmd_encher`, `cmd_vedar`, `cmd_verificar` out 1 each: slave commands (levels).
- `destino_cq` out 1: conveyor target. 0 = fill position, 1 = CQ position. Meaningful only while `cmd_mover`=1.
- `atuador_descarte` out 1: discard actuator.
- `linha_ativa` out 1: high in every state except IDLE and ERRO.
- `erro` out 1: watchdog trip.
- `cont_aprovadas`, `cont_descartes` out CONT_W each: bottle counters.

## Operation
- Reset values: state IDLE; all outputs 0; counters 0; stop latch 0; verdict register 0.
- Stop latch: set by `pulso_stop` in any state except IDLE/ERRO. Cleared on entry to IDLE.
- IDLE --`pulso_start` & !`pulso_stop`--> MOV_ENCH. If both pulses arrive in the same cycle, the stop wins and the block stays in IDLE.
- `pulso_start` is ignored outside IDLE and ERRO.
- Each task state has two phases, CMD and LIB:
  - CMD: its command is 1. Advance to LIB when its done input is 1.
  - LIB: command is 0. Advance when its done input is 0.
- Task order: MOV_ENCH (`cmd_mover`, `destino_cq`=0) -> ENCHER -> VEDAR -> MOV_CQ (`cmd_mover`, `destino_cq`=1) -> VERIFICAR (`cmd_verificar`).
- VERIFICAR CMD: `garrafa_aprovada` is sampled into the verdict register in the cycle `cq_concluida`=1 is seen.
- After VERIFICAR LIB:
  - Verdict 1: `cont_aprovadas`+1, then go to FIM.
  - Verdict 0: go to DESCARTE. On entry `cont_descartes`+1. `atuador_descarte`=1 for exactly DESCARTE_CICLOS cycles, then go to FIM.
- FIM (one cycle): stop latch set -> IDLE; otherwise -> MOV_ENCH (next bottle).
- Counters saturate at all-ones and never wrap.
- At most one command output is high at a time.

## Timing
- Outputs are Moore, decoded from the registered state.
- `pulso_start` in cycle n -> `cmd_mover`=1 in cycle n+1.
- Done seen high in cycle k -> command low in k+1.
- Done seen low in LIB in cycle k -> next command high in k+1.
- Counter increments are visible one cycle after the VERIFICAR-LIB exit.
- Reset asserted mid-operation forces IDLE and zeros everything immediately, asynchronously.

## Configuration
- `FSM_MESTRE_WATCHDOG_EN` defined:
  - A phase counter restarts on every state/phase change.
  - Reaching TIMEOUT_CICLOS in any CMD or LIB phase -> ERRO: all commands 0, actuator 0, `erro`=1.
  - ERRO --`pulso_start` with all four done inputs 0--> IDLE, with `erro` and the stop latch cleared.
  - Counters are preserved across ERRO.
- Undefined: no ERRO state and no phase counter; `erro` tied to 0; phases wait indefinitely.

## Structure
- Shared package `pkg_linha_envase`:
  - state encoding localparams (IDLE, MOV_ENCH, ENCHER, VEDAR, MOV_CQ, VERIFICAR, DESCARTE, FIM, ERRO);
  - phase encoding (CMD/LIB);
  - default cycle constants.
- One sub-module `contador_saturado`: CONT_W-wide counter with `inc` input, saturating. Instanced twice.
- DESCARTE and watchdog timers stay inline.

## Test plan
- Approved bottle, slaves answering after 3 cycles, `garrafa_aprovada`=1: command order is mover(0)/encher/vedar/mover(1)/verificar; `cont_aprovadas`=1; `cmd_mover` rises again for bottle 2.
- Rejected bottle, DESCARTE_CICLOS=4: `atuador_descarte` high exactly 4 cycles; `cont_descartes`=1; `cont_aprovadas`=0.
- `pulso_stop` during ENCHER: bottle completes through CQ, then IDLE with `linha_ativa`=0. Also `pulso_start` and `pulso_stop` in the same cycle in IDLE: stays IDLE.
- CONT_W=2, 5 approved bottles: `cont_aprovadas` stops at 3.
- `reset_n` low during VEDAR CMD: `cmd_vedar`=0 and counters 0 without waiting for a clock edge.
- With `FSM_MESTRE_WATCHDOG_EN`, TIMEOUT_CICLOS=10, `encher_concluida` stuck 0: ERRO after 10 cycles in ENCHER CMD with `erro`=1 and all commands 0; then `pulso_start` -> IDLE with `erro`=0.
